// File: rtl/mem_io_pkg.sv
// Shared decode constants, state/region types and a byte-select helper
// for the CPU memory-bus responder.
package mem_io_pkg;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_UART_OFF = 3'd0;
  localparam logic [2:0] IO_CLK_OFF  = 3'd4;

  typedef enum logic [1:0] {RUN, DRAIN, STOPPED} state_e;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_e;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO of depth 2^TXQ_WIDTH. Pushes into a full FIFO
// and pops from an empty one are ignored; head data is shown while non-empty.
module byte_fifo #(
  parameter int TXQ_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [7:0]           i_push_data,
  input  logic                 i_pop,
  output logic [7:0]           o_pop_data,
  output logic [TXQ_WIDTH:0]   o_count,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int DEPTH = 1 << TXQ_WIDTH;
  localparam logic [TXQ_WIDTH:0] DEPTH_C = (TXQ_WIDTH + 1)'(DEPTH);

  logic [7:0]           r_mem [DEPTH];
  logic [TXQ_WIDTH-1:0] r_wr_ptr;
  logic [TXQ_WIDTH-1:0] r_rd_ptr;
  logic [TXQ_WIDTH:0]   r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == DEPTH_C);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: RAM, UART TX/RX, cycle counter and the
// program-stop sequence, all answering reads with one cycle of latency.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TXQ_WIDTH      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_mem_a,
  input  logic        cpu_mem_wr,
  input  logic [7:0]  cpu_mem_dout,
  output logic [7:0]  cpu_mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        overflow_err,
  output logic [1:0]  o_dbg_state
);

  localparam int DEPTH = 1 << TXQ_WIDTH;
  localparam logic [TXQ_WIDTH:0] FULL_MARK = (TXQ_WIDTH + 1)'(DEPTH - 2);

  state_e               r_state;
  state_e               w_state_next;
  region_e              w_region;
  logic [31:0]          r_cnt;
  logic [31:0]          r_snap;
  logic [7:0]           r_din;
  logic                 r_buf_full;
  logic                 r_ovf;
  logic [7:0]           r_ram [2**RAM_ADDR_WIDTH];

  logic                 w_ram_hit;
  logic [2:0]           w_off;
  logic                 w_io_rd;
  logic                 w_io_wr;
  logic                 w_ram_we;
  logic                 w_uart_wr;
  logic                 w_stop_req;
  logic                 w_push;
  logic [7:0]           w_push_data;
  logic                 w_push_ok;
  logic                 w_pop;
  logic                 w_snap_load;
  logic [7:0]           w_rd_data;
  logic [7:0]           w_fifo_data;
  logic [TXQ_WIDTH:0]   w_fifo_count;
  logic [TXQ_WIDTH:0]   w_count_next;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_unused_addr;

  assign w_unused_addr = ^cpu_mem_a[31:18];
  assign w_ram_hit     = ((cpu_mem_a[17:0] >> RAM_ADDR_WIDTH) == 18'd0);
  assign w_off         = cpu_mem_a[2:0];

  always_comb begin
    w_region = REG_NONE;
    if (cpu_mem_a[17:16] == IO_SEL) w_region = REG_IO;
    else if (w_ram_hit)             w_region = REG_RAM;
  end

  assign w_io_rd     = !cpu_mem_wr && (w_region == REG_IO);
  assign w_io_wr     = cpu_mem_wr && (w_region == REG_IO) && (r_state == RUN);
  assign w_stop_req  = w_io_wr && w_off[2];
  assign w_uart_wr   = w_io_wr && (w_off == IO_UART_OFF) && (cpu_mem_dout != 8'h00);
  assign w_ram_we    = cpu_mem_wr && (w_region == REG_RAM) && (r_state != STOPPED);
  assign w_snap_load = w_io_rd && (w_off == IO_CLK_OFF);

  // The stop request enqueues a 0x00 terminator for the UART.
  assign w_push      = w_uart_wr || w_stop_req;
  assign w_push_data = w_stop_req ? 8'h00 : cpu_mem_dout;
  assign w_push_ok   = w_push && !w_fifo_full;

  // TX handshake: a byte transfers on any edge where tx_valid && tx_ready;
  // tx_data is stable while tx_valid is high and not yet accepted.
  assign w_pop    = !w_fifo_empty && tx_ready;
  assign tx_valid = !w_fifo_empty;
  assign tx_data  = w_fifo_data;
  assign rx_ready = !rst_in && w_io_rd && (w_off == IO_UART_OFF) && rx_valid;

  always_comb begin
    w_rd_data = 8'h00;
    if (!cpu_mem_wr) begin
      case (w_region)
        REG_RAM: w_rd_data = r_ram[cpu_mem_a[RAM_ADDR_WIDTH-1:0]];
        REG_IO: begin
          if (w_off == IO_UART_OFF)     w_rd_data = rx_valid ? rx_data : 8'h00;
          else if (w_off == IO_CLK_OFF) w_rd_data = r_cnt[7:0];
          else if (w_off[2])            w_rd_data = pick_byte(r_snap, w_off[1:0]);
          else                          w_rd_data = 8'h00;
        end
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_count_next = w_fifo_count;
    if (w_push_ok && !w_pop)      w_count_next = w_fifo_count + 1'b1;
    else if (!w_push_ok && w_pop) w_count_next = w_fifo_count - 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_stop_req) w_state_next = DRAIN;
      DRAIN:   if (w_fifo_empty && !w_push) w_state_next = STOPPED;
      STOPPED: w_state_next = STOPPED;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= RUN;
      r_cnt      <= 32'd0;
      r_snap     <= 32'd0;
      r_din      <= 8'h00;
      r_buf_full <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= r_cnt + 32'd1;
      r_din      <= w_rd_data;
      r_buf_full <= (w_count_next >= FULL_MARK);
      if (w_snap_load)           r_snap <= r_cnt;
      if (w_push && w_fifo_full) r_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_ram_we) r_ram[cpu_mem_a[RAM_ADDR_WIDTH-1:0]] <= cpu_mem_dout;
  end

  byte_fifo #(.TXQ_WIDTH(TXQ_WIDTH)) u_fifo (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign cpu_mem_din    = r_din;
  assign io_buffer_full = r_buf_full;
  assign program_stop   = (r_state == STOPPED);
  assign overflow_err   = r_ovf;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus (`mem_a`/`mem_wr`/`mem_dout`/`mem_din`/`io_buffer_full`). It decodes each bus cycle into RAM or memory-mapped I/O and returns read data one cycle later. It also buffers UART output in a TX FIFO, exposes a free-running cycle counter, and implements the program-stop sequence. It sits between the CPU top and the board RAM/UART glue, in place of a separate RAM plus host-interface pair.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, 17: RAM byte-address bits (128 KB).
- `TXQ_WIDTH`, 3: log2 of TX FIFO depth (8 entries).

Ports:
- `clk_in` in 1: the only clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `cpu_mem_a` in 32: byte address from CPU; only bits 17:0 are decoded.
- `cpu_mem_wr` in 1: 1 = write, 0 = read.
- `cpu_mem_dout` in 8: write data from CPU.
- `cpu_mem_din` out 8: read data to CPU, registered.
- `io_buffer_full` out 1: TX FIFO nearly full, registered.
- `tx_data` out 8: TX FIFO head.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: UART accepts `tx_data` this cycle.
- `rx_data` in 8: UART receive byte.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_ready` out 1: pop strobe to the UART RX, one cycle wide.
- `program_stop` out 1: sticky; program finished and TX has drained.
- `overflow_err` out 1: sticky; a UART write was dropped because the FIFO was full.

## Operation
- Decode:
  - `cpu_mem_a[17:16]==2'b11` selects I/O.
  - Otherwise, if `cpu_mem_a[17:RAM_ADDR_WIDTH]==0`, the cycle targets RAM.
  - Otherwise the address is unmapped: reads return 0x00 and writes are ignored.
- RAM: byte array, not reset.
  - Write commits at the clock edge.
  - Read data appears on `cpu_mem_din` the next cycle.
  - A read immediately after a write to the same address returns the new byte.
- I/O decode uses `cpu_mem_a[2:0]`:
  - Read 0: returns `rx_valid ? rx_data : 0x00`. `rx_ready` pulses in the same cycle only if `rx_valid`.
  - Write 0: pushes `cpu_mem_dout` into the TX FIFO. A write of 0x00 is ignored.
  - Read 1–3: return 0x00. Write 1–3: ignored.
  - Read 4–7: byte `cpu_mem_a[1:0]` (little-endian) of the counter snapshot. A read at offset 4 loads the snapshot from the live counter, and that same read returns byte 0 of the new value.
  - Write 4–7: stop request.
- Cycle counter: 32-bit, increments every cycle after reset and wraps 0xFFFFFFFF→0.
- TX FIFO:
  - Depth 2^`TXQ_WIDTH`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo depth.
  - A push when count==depth is dropped and sets `overflow_err`.
- Stop state machine:
  - `RUN`: on a stop-request write, push 0x00 into the FIFO (the UART terminator), then go to `DRAIN`.
  - `DRAIN`: further I/O writes are ignored; RAM keeps operating. Go to `STOPPED` when the FIFO is empty and no push is pending.
  - `STOPPED`: `program_stop`=1. All writes, RAM included, are ignored. Reads still serve. Only reset exits.
- Reset mid-operation: the FIFO empties, any pending `tx_valid` byte is lost, and the state returns to `RUN`.

## Timing
- Reset values:
  - `cpu_mem_din`=0x00, `io_buffer_full`=0, `tx_valid`=0, `rx_ready`=0.
  - `program_stop`=0, `overflow_err`=0, counter=0, state `RUN`.
- Read latency: exactly 1 cycle, for every region. Address and `wr` are sampled at edge N; data is valid after edge N+1.
- Write latency: 0 wait states; the CPU may issue a new cycle every clock.
- `io_buffer_full` is registered and set when the post-update count ≥ depth−2. This covers one in-flight write and the flag's own cycle of lag.
- `tx_valid` goes high the cycle after a push into an empty FIFO. A transfer occurs on an edge where `tx_valid && tx_ready`.
- `rx_ready` is combinational from the decode of the current cycle, so the pop occurs on the same edge as the read sample.

## Structure
- Package `mem_io_pkg`:
  - `IO_SEL=2'b11`, `IO_UART_OFF=3'd0`, `IO_CLK_OFF=3'd4`.
  - State enum `{RUN, DRAIN, STOPPED}`.
  - Region enum `{REG_RAM, REG_IO, REG_NONE}`.
- Sub-module `byte_fifo`, parameterised by `TXQ_WIDTH`, with ports push/pop/data/count/empty/full. The responder instantiates it once.
- RAM is an inferred single-port array inside the top.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 on the next cycle → `cpu_mem_din`=0xA5 one cycle after the read.
- Write 0x41, 0x00, 0x42 to 0x30000 with `tx_ready`=0 → FIFO count 2, `tx_data`=0x41. Raise `tx_ready` → bytes 0x41 then 0x42 transfer.
- Write 9 nonzero bytes to 0x30000 with `tx_ready`=0 → `io_buffer_full`=1 after the 6th push, 9th push dropped, `overflow_err`=1.
- Run 0x123 cycles after reset, then read 0x30004–0x30007 → bytes form the counter value at the offset-4 read (0x00000123 + read cycle offset). Bytes 5–7 are coherent even across a low-byte wrap.
- Read 0x30000 with `rx_valid`=1, `rx_data`=0x37 → `cpu_mem_din`=0x37 and a one-cycle `rx_ready`. With `rx_valid`=0 → 0x00 and no pulse.
- Queue 2 bytes, write 0x30004, hold `tx_ready`=1 → TX emits both bytes then 0x00, `program_stop`=1 the cycle after the FIFO empties, and a following RAM write has no effect.
